// File: rtl/aes_core_stream.sv
// AES-128 streaming encryption core: unrolled round chain,
// valid/ready handshakes, sideband tag and synchronous flush.
package aes_core_stream_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a,
                                      input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
           rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

module aes_round (
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         final_round,
  output logic [127:0] st_next
);
  import aes_core_stream_pkg::*;

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    st_next = '0;
    for (int i = 0; i < 16; i++)
      sb[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        mc[4*c+r] = xt(sr[4*c+r]) ^
                    xt(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4] ^
                    sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
    for (int i = 0; i < 16; i++)
      st_next[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^
                              rk[127-8*i -: 8];
  end
endmodule

module aes_key_expand_128 (
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);
  import aes_core_stream_pkg::*;

  logic [31:0] w0, w1, w2, w3, t;

  assign {w0, w1, w2, w3} = rk;
  assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]),
              sbox(w3[7:0]), sbox(w3[31:24])};
  assign rk_next = {w0 ^ t, w0 ^ w1 ^ t,
                    w0 ^ w1 ^ w2 ^ t, w0 ^ w1 ^ w2 ^ w3 ^ t};
endmodule

module aes_core_stream #(
  parameter int UNROLL = 1,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_key,
  input  logic [127:0]     in_pt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_ct,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  import aes_core_stream_pkg::*;

  if (!(UNROLL == 1 || UNROLL == 2 ||
        UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_core_stream: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } fsm_t;

  fsm_t fsm_q, fsm_nx;

  logic [127:0]          st_q, rk_q;
  logic [3:0]            rnd_q;
  logic [TAG_W-1:0]      tag_q;
  logic [UNROLL:0][127:0] st_c, rk_c;
  logic                  acc, last;

  assign st_c[0] = st_q;
  assign rk_c[0] = rk_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_stage
    logic [3:0] r;
    assign r = rnd_q + 4'(k);
    aes_key_expand_128 u_ke (
      .rk      (rk_c[k]),
      .rcon    (rcon(r)),
      .rk_next (rk_c[k+1])
    );
    aes_round u_rd (
      .st          (st_c[k]),
      .rk          (rk_c[k+1]),
      .final_round (r == 4'd10),
      .st_next     (st_c[k+1])
    );
  end

  assign in_ready = !rst && !flush &&
                    (fsm_q == ST_IDLE ||
                     (fsm_q == ST_OUT && out_ready));
  assign acc  = in_valid && in_ready;
  assign last = (fsm_q == ST_RUN) &&
                (rnd_q + 4'(UNROLL - 1) == 4'd10);
  assign busy = (fsm_q == ST_RUN);

  always_comb begin
    fsm_nx = fsm_q;
    unique case (1'b1)
      fsm_q == ST_IDLE: if (acc) fsm_nx = ST_RUN;
      fsm_q == ST_RUN:  if (last) fsm_nx = ST_OUT;
      fsm_q == ST_OUT: begin
        if (acc) fsm_nx = ST_RUN;
        else if (out_ready) fsm_nx = ST_IDLE;
      end
      default: fsm_nx = ST_IDLE;
    endcase
    if (flush) fsm_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= '0;
      rk_q      <= '0;
      rnd_q     <= '0;
      tag_q     <= '0;
      out_valid <= 1'b0;
      out_ct    <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      rnd_q     <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // a load in ST_OUT overlaps the drain of the held result
      if (acc) begin
        st_q  <= in_pt ^ in_key;
        rk_q  <= in_key;
        rnd_q <= 4'd1;
        tag_q <= in_tag;
      end else if (fsm_q == ST_RUN) begin
        st_q  <= st_c[UNROLL];
        rk_q  <= rk_c[UNROLL];
        rnd_q <= last ? 4'd0 : rnd_q + 4'(UNROLL);
        if (last) begin
          out_ct    <= st_c[UNROLL];
          out_tag   <= tag_q;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_core_stream.sv
// Bench for aes_core_stream: four instances (UNROLL 1/2/5/10)
// checked every cycle against a byte-level AES/handshake model.
module tb_aes_core_stream;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

  function automatic int ul(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 10;
    endcase
  endfunction

  function automatic int lat_exp(input int g);
    case (g)
      0:       return 11;
      1:       return 6;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  logic         clk, rst, flush;
  logic [127:0] in_key, in_pt;
  logic [7:0]   in_tag;
  logic         in_valid [4];
  logic         out_ready [4];
  logic         in_ready [4];
  logic         out_valid [4];
  logic         busy [4];
  logic [127:0] out_ct [4];
  logic [7:0]   out_tag [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes_core_stream #(.UNROLL(ul(g)), .TAG_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_key    (in_key),
      .in_pt     (in_pt),
      .in_tag    (in_tag),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_ct    (out_ct[g]),
      .out_tag   (out_tag[g]),
      .busy      (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int pcyc  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  // Reference AES: S-box built by walking the field with generator 3
  logic [7:0] sb [256];

  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic void build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key,
                                           input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  x;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sb[x[23:16]] ^ rc, sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]};
        rc = m2(rc);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c+j] = t[4*((c+j)%4)+j];
      if (r < 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++)
            s[4*c+j] = m2(t[4*c+j]) ^ m2(t[4*c+(j+1)%4]) ^
                       t[4*c+(j+1)%4] ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Cycle-level model: busy countdown, held result, observed handshakes
  int           m_cnt [4];
  bit           m_ov [4];
  logic [127:0] m_ct [4], m_pct [4];
  logic [7:0]   m_tag [4], m_ptag [4];
  logic [135:0] got_q [4][$];
  logic         er;

  initial begin
    for (int d = 0; d < 4; d++) begin
      m_cnt[d] = 0;
      m_ov[d]  = 1'b0;
      m_ct[d]  = '0;
      m_tag[d] = '0;
      m_pct[d] = '0;
      m_ptag[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        er = !rst && !flush &&
             ((m_cnt[d] == 0 && !m_ov[d]) || (m_ov[d] && out_ready[d]));
        if (chk_en) begin
          chk($sformatf("d%0d in_ready", d), 128'(in_ready[d]), 128'(er));
          chk($sformatf("d%0d out_valid", d), 128'(out_valid[d]),
              128'(m_ov[d]));
          chk($sformatf("d%0d busy", d), 128'(busy[d]),
              128'(m_cnt[d] != 0));
          if (m_ov[d]) begin
            chk($sformatf("d%0d out_ct", d), out_ct[d], m_ct[d]);
            chk($sformatf("d%0d out_tag", d), 128'(out_tag[d]),
                128'(m_tag[d]));
          end
        end
        if (out_valid[d] && out_ready[d] && !rst && !flush)
          got_q[d].push_back({out_tag[d], out_ct[d]});
        if (rst) begin
          m_cnt[d] = 0;
          m_ov[d]  = 1'b0;
          m_ct[d]  = '0;
          m_tag[d] = '0;
        end else if (flush) begin
          m_cnt[d] = 0;
          m_ov[d]  = 1'b0;
        end else begin
          if (m_cnt[d] > 0) begin
            m_cnt[d]--;
            if (m_cnt[d] == 0) begin
              m_ov[d]  = 1'b1;
              m_ct[d]  = m_pct[d];
              m_tag[d] = m_ptag[d];
            end
          end else if (m_ov[d] && out_ready[d]) begin
            m_ov[d] = 1'b0;
          end
          if (in_valid[d] && er) begin
            m_pct[d]  = aes_ref(in_key, in_pt);
            m_ptag[d] = in_tag;
            m_cnt[d]  = 10 / ul(d);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      pcyc++;
    end
  end

  task automatic send(input int d, input logic [127:0] k,
                      input logic [127:0] p, input logic [7:0] t,
                      input bit drop, output int ac);
    int n;
    in_key = k;
    in_pt  = p;
    in_tag = t;
    in_valid[d] = 1'b1;
    n  = 0;
    ac = -1;
    do begin
      nedge();
      n++;
    end while (!in_ready[d] && n < 100);
    if (!in_ready[d]) begin
      fail_to($sformatf("d%0d accept", d));
      in_valid[d] = 1'b0;
    end else begin
      pedge();
      ac = pcyc;
      if (drop) in_valid[d] = 1'b0;
    end
  endtask

  task automatic wait_ov(input int d, output int n);
    n = 0;
    do begin
      nedge();
      n++;
    end while (!out_valid[d] && n < 60);
    if (!out_valid[d]) fail_to($sformatf("d%0d out_valid", d));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n, ac;
  int acs [4];
  int seen;
  logic [135:0] e;

  initial begin
    build_sbox();
    rst = 1'b1;
    flush = 1'b0;
    in_key = '0;
    in_pt = '0;
    in_tag = '0;
    for (int d = 0; d < 4; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    chk("model C.1", aes_ref(KC, PC), CC);
    chk("model App.B", aes_ref(KB, PB), CB);

    // reset
    repeat (3) pedge();
    nedge();
    chk("in_ready in rst", 128'(in_ready[0]), 128'(0));
    pedge();
    rst = 1'b0;
    chk_en = 1'b1;
    nedge();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d rst out_ct", d), out_ct[d], 128'(0));
      chk($sformatf("d%0d rst out_tag", d), 128'(out_tag[d]), 128'(0));
      chk($sformatf("d%0d rst out_valid", d), 128'(out_valid[d]), 128'(0));
      chk($sformatf("d%0d rst busy", d), 128'(busy[d]), 128'(0));
      chk($sformatf("d%0d idle in_ready", d), 128'(in_ready[d]), 128'(1));
    end
    pedge();

    // C.1 on UNROLL=1
    send(0, KC, PC, 8'h5a, 1'b1, ac);
    wait_ov(0, n);
    chk("C.1 latency", 128'(n), 128'(11));
    chk("C.1 ct", out_ct[0], CC);
    chk("C.1 tag", 128'(out_tag[0]), 128'(8'h5a));
    pedge();

    // App.B on UNROLL=2,5,10
    for (int d = 1; d < 4; d++) begin
      send(d, KB, PB, 8'(8'h10 + d), 1'b1, ac);
      wait_ov(d, n);
      chk($sformatf("d%0d App.B latency", d), 128'(n), 128'(lat_exp(d)));
      chk($sformatf("d%0d App.B ct", d), out_ct[d], CB);
      chk($sformatf("d%0d App.B tag", d), 128'(out_tag[d]),
          128'(8'h10 + d));
      pedge();
    end

    // back-pressure
    out_ready[0] = 1'b0;
    send(0, KC, PC, 8'h33, 1'b1, ac);
    wait_ov(0, n);
    got_q[0].delete();
    repeat (20) begin
      nedge();
      chk("bp ct", out_ct[0], CC);
      chk("bp tag", 128'(out_tag[0]), 128'(8'h33));
      chk("bp in_ready", 128'(in_ready[0]), 128'(0));
      chk("bp busy", 128'(busy[0]), 128'(0));
    end
    pedge();
    out_ready[0] = 1'b1;
    nedge();
    chk("bp release valid", 128'(out_valid[0]), 128'(1));
    pedge();
    nedge();
    chk("bp drained", 128'(out_valid[0]), 128'(0));
    chk("bp idle in_ready", 128'(in_ready[0]), 128'(1));
    repeat (3) nedge();
    chk("bp handshakes", 128'(got_q[0].size()), 128'(1));
    pedge();

    // back-to-back on UNROLL=1 and UNROLL=2
    for (int d = 0; d < 2; d++) begin
      got_q[d].delete();
      for (int i = 0; i < 4; i++) begin
        if (i % 2 == 1) send(d, KB, PB, 8'(i), i == 3, acs[i]);
        else            send(d, KC, PC, 8'(i), i == 3, acs[i]);
      end
      for (int i = 1; i < 4; i++)
        chk($sformatf("d%0d b2b period %0d", d, i),
            128'(acs[i] - acs[i-1]), 128'(lat_exp(d)));
      wait_ov(d, n);
      nedge();
      seen = got_q[d].size();
      chk($sformatf("d%0d b2b count", d), 128'(seen), 128'(4));
      for (int i = 0; i < 4 && i < seen; i++) begin
        e = got_q[d].pop_front();
        chk($sformatf("d%0d b2b tag %0d", d, i), 128'(e[135:128]),
            128'(i));
        chk($sformatf("d%0d b2b ct %0d", d, i), e[127:0],
            (i % 2 == 1) ? CB : CC);
      end
      pedge();
    end

    // flush mid-RUN
    send(0, KC, PC, 8'h21, 1'b1, ac);
    repeat (3) pedge();
    flush = 1'b1;
    nedge();
    chk("flush in_ready", 128'(in_ready[0]), 128'(0));
    chk("flush busy before", 128'(busy[0]), 128'(1));
    pedge();
    flush = 1'b0;
    nedge();
    chk("flush busy after", 128'(busy[0]), 128'(0));
    chk("flush in_ready after", 128'(in_ready[0]), 128'(1));
    seen = 0;
    repeat (15) begin
      nedge();
      if (out_valid[0]) seen++;
    end
    chk("flush no output", 128'(seen), 128'(0));
    pedge();
    send(0, KC, PC, 8'h66, 1'b1, ac);
    wait_ov(0, n);
    chk("post-flush latency", 128'(n), 128'(11));
    chk("post-flush ct", out_ct[0], CC);
    chk("post-flush tag", 128'(out_tag[0]), 128'(8'h66));
    pedge();

    // flush while holding a result
    out_ready[2] = 1'b0;
    send(2, KB, PB, 8'h44, 1'b1, ac);
    wait_ov(2, n);
    chk("out-flush latency", 128'(n), 128'(3));
    pedge();
    flush = 1'b1;
    nedge();
    chk("out-flush still valid", 128'(out_valid[2]), 128'(1));
    chk("out-flush in_ready", 128'(in_ready[2]), 128'(0));
    pedge();
    flush = 1'b0;
    nedge();
    chk("out-flush dropped", 128'(out_valid[2]), 128'(0));
    chk("out-flush idle", 128'(in_ready[2]), 128'(1));
    pedge();
    out_ready[2] = 1'b1;

    // reset mid-RUN
    send(0, KC, PC, 8'h77, 1'b1, ac);
    repeat (6) pedge();
    rst = 1'b1;
    nedge();
    chk("rst-mid in_ready", 128'(in_ready[0]), 128'(0));
    pedge();
    rst = 1'b0;
    nedge();
    chk("rst-mid out_valid", 128'(out_valid[0]), 128'(0));
    chk("rst-mid out_ct", out_ct[0], 128'(0));
    chk("rst-mid out_tag", 128'(out_tag[0]), 128'(0));
    chk("rst-mid busy", 128'(busy[0]), 128'(0));
    seen = 0;
    repeat (15) begin
      nedge();
      if (out_valid[0]) seen++;
    end
    chk("rst-mid no output", 128'(seen), 128'(0));
    pedge();
    send(0, KB, PB, 8'h88, 1'b1, ac);
    wait_ov(0, n);
    chk("post-rst latency", 128'(n), 128'(11));
    chk("post-rst ct", out_ct[0], CB);
    chk("post-rst tag", 128'(out_tag[0]), 128'(8'h88));
    pedge();
    repeat (4) pedge();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
